// File: rtl/mito_wgt_pkg.sv
// -----------------------------------------------------------------------------
// mito_wgt_pkg
// Shared constants, state type and lane helper for the weight-kernel packer.
//
// Contents:
//   BYTE_WIDTH, WORD_WIDTH    width of one weight and of one packed word
//   KERNEL_SIZE               weights per 3x3 kernel
//   INPUT_WGT_REG             packed words per kernel (one per kernel row)
//   wgt_pack_state_e          FILL / HOLD / SEND packer states
//   lane_msb(k)               MSB position of weight k inside its packed word
// -----------------------------------------------------------------------------
package mito_wgt_pkg;

   localparam int BYTE_WIDTH    = 8;
   localparam int WORD_WIDTH    = 32;
   localparam int KERNEL_SIZE   = 9;
   localparam int INPUT_WGT_REG = 3;

   typedef enum logic [1:0] {
      FILL = 2'd0,
      HOLD = 2'd1,
      SEND = 2'd2
   } wgt_pack_state_e;

   // The first weight of a row sits in bits [23:16], the last in [7:0];
   // bits [31:24] are never written so they stay zero.
   function automatic int unsigned lane_msb(input int unsigned k);
      return 23 - 8 * (k % 3);
   endfunction

endpackage

// File: rtl/wgt_kernel_packer.sv
// -----------------------------------------------------------------------------
// wgt_kernel_packer
// Gathers one 3x3 kernel from a row-major byte stream into three 32-bit words
// (three weights per word) and then strobes wgt_read for one cycle so the
// PE-array weight buffer captures every word at once. A complete kernel is
// held until the array allows a reload through load_en.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   upstream byte valid
//   in_ready   packer accepts a byte this cycle
//   in_wgt     signed weight byte, kernel raster order
//   in_last    marks the final byte (index 8) of a kernel
//   load_en    PE array permits weight-buffer reload
//   wgt_word   packed kernel words, word i at bits [WORD_WIDTH*i +: WORD_WIDTH]
//   wgt_read   one-cycle load strobe to the weight buffer
//   frame_err  sticky flag: in_last did not line up with the byte count
// -----------------------------------------------------------------------------
module wgt_kernel_packer
   import mito_wgt_pkg::*;
#(
   parameter int BYTE_WIDTH    = mito_wgt_pkg::BYTE_WIDTH,
   parameter int WORD_WIDTH    = mito_wgt_pkg::WORD_WIDTH,
   parameter int INPUT_WGT_REG = mito_wgt_pkg::INPUT_WGT_REG,
   parameter int PE_ARR_SIZE   = mito_wgt_pkg::KERNEL_SIZE
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [BYTE_WIDTH-1:0]               in_wgt,
   input  logic                                in_last,
   input  logic                                load_en,
   output logic [INPUT_WGT_REG*WORD_WIDTH-1:0] wgt_word,
   output logic                                wgt_read,
   output logic                                frame_err
);

   localparam int CNT_W = 4;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PE_ARR_SIZE - 1);

   wgt_pack_state_e                                state_q, state_d;
   logic [CNT_W-1:0]                               cnt_q, cnt_d;
   logic [INPUT_WGT_REG-1:0][WORD_WIDTH-1:0]       words_q, words_d;
   logic                                           frame_err_q, frame_err_d;
   logic                                           wgt_read_q, wgt_read_d;
   logic                                           accept;

   // The packer only refuses bytes while it is holding a finished kernel;
   // in SEND it already takes byte 0 of the next kernel. The words register
   // changes at the edge ending SEND, after the buffer has sampled it.
   assign in_ready  = rst_n && (state_q != HOLD);
   assign accept    = in_valid && in_ready;
   assign wgt_word  = words_q;
   assign wgt_read  = wgt_read_q;
   assign frame_err = frame_err_q;

   // Next-state logic: steer each accepted byte into its lane, advance the
   // byte counter and detect framing problems. A premature in_last drops the
   // partial kernel by rewinding the counter, while a missing in_last on the
   // ninth byte is flagged but the kernel still goes out.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      words_d     = words_q;
      frame_err_d = frame_err_q;

      case (state_q)
         FILL, SEND: begin
            if (state_q == SEND) begin
               state_d = FILL;
            end
            if (accept) begin
               for (int k = 0; k < PE_ARR_SIZE; k++) begin
                  if (cnt_q == CNT_W'(k)) begin
                     words_d[k / 3][lane_msb(k) -: BYTE_WIDTH] = in_wgt;
                  end
               end
               if (cnt_q == LAST_IDX) begin
                  state_d = HOLD;
                  cnt_d   = '0;
                  if (!in_last) begin
                     frame_err_d = 1'b1;
                  end
               end else if (in_last) begin
                  frame_err_d = 1'b1;
                  cnt_d       = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         HOLD: begin
            if (load_en) begin
               state_d = SEND;
            end
         end
         default: begin
            state_d = FILL;
            cnt_d   = '0;
         end
      endcase

      wgt_read_d = (state_d == SEND);
   end

   // State and datapath registers. Reset throws away any partial kernel and
   // clears the sticky framing flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= FILL;
         cnt_q       <= '0;
         words_q     <= '0;
         frame_err_q <= 1'b0;
         wgt_read_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         words_q     <= words_d;
         frame_err_q <= frame_err_d;
         wgt_read_q  <= wgt_read_d;
      end
   end

endmodule
